// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, controller states, instruction
// classes and the datapath select encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI16 = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;

  localparam logic [1:0] WR_RT    = 2'b00;
  localparam logic [1:0] WR_RD    = 2'b01;
  localparam logic [1:0] WR_31    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DCD, EXE, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_J, CLS_JAL, CLS_ILL
  } cls_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic       b_sel;
  } exe_sel_t;

  // ALU/operand selects set up in EXE and held through the memory/writeback states
  function automatic exe_sel_t exe_sel(cls_e cls);
    exe_sel_t s;
    s = '0;
    case (cls)
      CLS_ADDU: s = '{alu_op: ALU_ADD, ext_op: EXT_ZERO, b_sel: 1'b0};
      CLS_SUBU: s = '{alu_op: ALU_SUB, ext_op: EXT_ZERO, b_sel: 1'b0};
      CLS_ORI:  s = '{alu_op: ALU_OR,  ext_op: EXT_ZERO, b_sel: 1'b1};
      CLS_LUI:  s = '{alu_op: ALU_ADD, ext_op: EXT_HI16, b_sel: 1'b1};
      CLS_LW,
      CLS_SW:   s = '{alu_op: ALU_ADD, ext_op: EXT_SIGN, b_sel: 1'b1};
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath (slave).
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic [1:0] EXTOp;
  logic [1:0] ALUOp;
  logic [1:0] NPCOp;
  logic       BSel;
  logic [1:0] WRSel;
  logic [1:0] WDSel;
  logic       illegal;
  logic       instret;

  modport master (
    input  Op, Funct, Zero,
    output PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WRSel, WDSel,
           illegal, instret
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WRSel, WDSel,
           illegal, instret
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: Op/Funct to instruction class.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls = CLS_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_ILL;
    endcase
    illegal = (cls == CLS_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences each instruction through
// FETCH/DCD/EXE/MEM/WB and drives all datapath enables and selects.
module mc_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);

  cls_e     cls;
  logic     dec_illegal;
  exe_sel_t sel;
  state_e   state_q, state_d;

  logic       pc_wr, ir_wr, rf_wr, dm_wr, b_sel, illegal, instret;
  logic [1:0] ext_op, alu_op, npc_op, wr_sel, wd_sel;

  mc_decode u_decode (
    .op      (bus.Op),
    .funct   (bus.Funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign sel = exe_sel(cls);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    b_sel   = 1'b0;
    illegal = 1'b0;
    instret = 1'b0;
    ext_op  = '0;
    alu_op  = '0;
    npc_op  = '0;
    wr_sel  = '0;
    wd_sel  = '0;
    case (state_q)
      FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        npc_op  = NPC_PC4;
        state_d = DCD;
      end
      DCD: begin
        case (cls)
          CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW: state_d = EXE;
          CLS_BEQ:        state_d = BRANCH;
          CLS_J, CLS_JAL: state_d = JUMP;
          default: begin
            illegal = dec_illegal;
            state_d = FETCH;
          end
        endcase
      end
      EXE: begin
        {alu_op, ext_op, b_sel} = sel;
        if (cls == CLS_LW)      state_d = MEM_RD;
        else if (cls == CLS_SW) state_d = MEM_WR;
        else                    state_d = WB_ALU;
      end
      MEM_RD: begin
        {alu_op, ext_op, b_sel} = sel;
        state_d = WB_MEM;
      end
      MEM_WR: begin
        {alu_op, ext_op, b_sel} = sel;
        dm_wr   = 1'b1;
        instret = 1'b1;
        state_d = FETCH;
      end
      WB_ALU: begin
        {alu_op, ext_op, b_sel} = sel;
        rf_wr   = 1'b1;
        wd_sel  = WD_ALU;
        wr_sel  = (cls == CLS_ADDU || cls == CLS_SUBU) ? WR_RD : WR_RT;
        instret = 1'b1;
        state_d = FETCH;
      end
      WB_MEM: begin
        rf_wr   = 1'b1;
        wd_sel  = WD_DM;
        wr_sel  = WR_RT;
        instret = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_op  = ALU_SUB;
        npc_op  = NPC_BR;
        pc_wr   = bus.Zero;
        instret = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        pc_wr   = 1'b1;
        npc_op  = NPC_J;
        if (cls == CLS_JAL) begin
          rf_wr  = 1'b1;
          wr_sel = WR_31;
          wd_sel = WD_PC;
        end
        instret = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset masks outputs combinationally so an aborted instruction commits nothing
    if (rst) begin
      {pc_wr, ir_wr, rf_wr, dm_wr, b_sel, illegal, instret} = '0;
      {ext_op, alu_op, npc_op, wr_sel, wd_sel} = '0;
    end
  end

  assign bus.PCWr    = pc_wr;
  assign bus.IRWr    = ir_wr;
  assign bus.RFWr    = rf_wr;
  assign bus.DMWr    = dm_wr;
  assign bus.EXTOp   = ext_op;
  assign bus.ALUOp   = alu_op;
  assign bus.NPCOp   = npc_op;
  assign bus.BSel    = b_sel;
  assign bus.WRSel   = wr_sel;
  assign bus.WDSel   = wd_sel;
  assign bus.illegal = illegal;
  assign bus.instret = instret;

endmodule
